// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 main controller.
// The controller and its ALU decoder both import this package.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Immediate format follows the opcode alone, so it is valid in every state.
  function automatic logic [1:0] imd_src_of(input logic [6:0] op);
    case (op)
      OP_SW:     imd_src_of = IMM_S;
      OP_BRANCH: imd_src_of = IMM_B;
      OP_JAL:    imd_src_of = IMM_J;
      default:   imd_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu_decoder.sv
// Combinational ALU operation decode from aluop, funct3 and the sub/add qualifier.
module cpu_alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        op5,
  output alu_ctrl_t   alu_ctrl,
  output logic        illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    // Flag depends on funct3 only; the controller qualifies it with state and opcode.
    illegal  = 1'b0;
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: illegal = 1'b0;
      default:                        illegal = 1'b1;
    endcase
    case (aluop)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select and enable combinationally from the state.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] imd_src,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  state_t    state;
  aluop_t    aluop;
  alu_ctrl_t alu_ctrl_w;
  logic      funct_illegal;
  logic      pc_en, mem_wr, ir_en, rf_en, illegal_raw;

  cpu_alu_decoder u_alu_dec (
    .aluop    (aluop),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .op5      (opcode[5]),
    .alu_ctrl (alu_ctrl_w),
    .illegal  (funct_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXEC_R;
            OP_I:         state <= S_EXEC_I;
            OP_JAL:       state <= S_JAL;
            OP_BRANCH:    state <= S_BRANCH;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXEC_R:   state <= S_ALUWB;
        S_EXEC_I:   state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_BRANCH:   state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    adr_src     = 1'b0;
    mem_wr      = 1'b0;
    ir_en       = 1'b0;
    rf_en       = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    aluop       = ALUOP_ADD;
    illegal_raw = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_en      = mem_ready;
        ir_en      = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW, OP_JAL: illegal_raw = 1'b0;
          OP_R, OP_I:           illegal_raw = funct_illegal;
          OP_BRANCH:            illegal_raw = (funct3[2:1] != 2'b00);
          default:              illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        rf_en      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_wr  = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        aluop     = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB:    rf_en = 1'b1;
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        aluop     = ALUOP_SUB;
        pc_en     = zero ^ funct3[0];
      end
      default: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
    endcase
  end

  // Enables are gated by rst_n so an in-flight strobe drops the instant reset asserts.
  assign pc_write      = pc_en & rst_n;
  assign mem_write     = mem_wr & rst_n;
  assign ir_write      = ir_en & rst_n;
  assign reg_write     = rf_en & rst_n;
  assign illegal_instr = illegal_raw & rst_n;
  assign alu_ctrl      = alu_ctrl_w;
  assign imd_src       = imd_src_of(opcode);
  assign state_dbg     = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: walks each instruction class through its
// state sequence and checks selects, enables, latency and reset behaviour.
module tb_cpu_control_fsm;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imd_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_control_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_ctrl      (alu_ctrl),
    .imd_src       (imd_src),
    .illegal_instr (illegal_instr),
    .state_dbg     (state_dbg)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH, completes the fetch and stops mid-cycle in DECODE.
  task automatic go_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input string tag);
    opcode = op; funct3 = f3; funct7_5 = f7; mem_ready = 1'b1; zero = 1'b0;
    #1;
    chk({tag, "_fetch"}, 8'(state_dbg), 8'(S_FETCH));
    tick();
    mem_ready = 1'b0;
    #1;
    chk({tag, "_decode"}, 8'(state_dbg), 8'(S_DECODE));
  endtask

  logic       mr_pat[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [6:0] at_op[5]  = '{OP_R, OP_I, OP_R, OP_I, OP_R};
  logic [2:0] at_f3[5]  = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
  logic       at_f7[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [2:0] at_exp[5] = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010};
  logic [2:0] br_f3[4]  = '{3'b000, 3'b000, 3'b001, 3'b001};
  logic       br_z[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       br_pc[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = OP_LW; funct3 = 3'b010; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_state", 8'(state_dbg), 8'(S_FETCH));
    chk("rst_pc_write", 8'(pc_write), 8'd0);
    chk("rst_ir_write", 8'(ir_write), 8'd0);
    chk("rst_reg_write", 8'(reg_write), 8'd0);
    chk("rst_mem_write", 8'(mem_write), 8'd0);
    chk("rst_illegal", 8'(illegal_instr), 8'd0);
    chk("rst_src_b", 8'(alu_src_b), 8'd2);
    chk("rst_result_src", 8'(result_src), 8'd2);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // lw with two fetch stalls and one read stall
    exp_q = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD,
              S_MEMWB, S_FETCH};
    for (int i = 0; i < 9; i++) begin
      logic [3:0] st;
      mem_ready = mr_pat[i];
      #1;
      st = exp_q.pop_front();
      chk("lw_state", 8'(state_dbg), 8'(st));
      chk("lw_ir_write", 8'(ir_write), 8'((st == S_FETCH) && mr_pat[i]));
      chk("lw_reg_write", 8'(reg_write), 8'(st == S_MEMWB));
      chk("lw_imd_src", 8'(imd_src), 8'd0);
      if (i == 7) chk("lw_result_src", 8'(result_src), 8'd1);
      if (i == 5) chk("lw_adr_src", 8'(adr_src), 8'd1);
      tick();
    end

    // sw without stalls
    go_decode(OP_SW, 3'b010, 1'b0, "sw");
    chk("sw_imd_src", 8'(imd_src), 8'd1);
    tick();
    chk("sw_memadr", 8'(state_dbg), 8'(S_MEMADR));
    chk("sw_memadr_src_a", 8'(alu_src_a), 8'd2);
    chk("sw_memadr_mem_write", 8'(mem_write), 8'd0);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("sw_memwrite", 8'(state_dbg), 8'(S_MEMWRITE));
    chk("sw_mem_write", 8'(mem_write), 8'd1);
    chk("sw_adr_src", 8'(adr_src), 8'd1);
    chk("sw_reg_write", 8'(reg_write), 8'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("sw_end_state", 8'(state_dbg), 8'(S_FETCH));
    chk("sw_end_mem_write", 8'(mem_write), 8'd0);

    // R-type and I-ALU decode table
    for (int i = 0; i < 5; i++) begin
      go_decode(at_op[i], at_f3[i], at_f7[i], "alu");
      chk("alu_decode_illegal", 8'(illegal_instr), 8'd0);
      chk("alu_decode_ctrl", 8'(alu_ctrl), 8'd0);
      tick();
      chk("alu_exec_state", 8'(state_dbg), (at_op[i] == OP_R) ? 8'(S_EXEC_R) : 8'(S_EXEC_I));
      chk("alu_exec_ctrl", 8'(alu_ctrl), 8'(at_exp[i]));
      chk("alu_exec_src_a", 8'(alu_src_a), 8'd2);
      chk("alu_exec_src_b", 8'(alu_src_b), (at_op[i] == OP_R) ? 8'd0 : 8'd1);
      tick();
      chk("alu_wb_state", 8'(state_dbg), 8'(S_ALUWB));
      chk("alu_wb_reg_write", 8'(reg_write), 8'd1);
      chk("alu_wb_result_src", 8'(result_src), 8'd0);
      tick();
      chk("alu_end_state", 8'(state_dbg), 8'(S_FETCH));
    end

    // beq / bne
    for (int i = 0; i < 4; i++) begin
      go_decode(OP_BRANCH, br_f3[i], 1'b0, "br");
      chk("br_decode_imd", 8'(imd_src), 8'd2);
      tick();
      zero = br_z[i];
      #1;
      chk("br_state", 8'(state_dbg), 8'(S_BRANCH));
      chk("br_pc_write", 8'(pc_write), 8'(br_pc[i]));
      chk("br_alu_ctrl", 8'(alu_ctrl), 8'd1);
      chk("br_imd", 8'(imd_src), 8'd2);
      tick();
      chk("br_end_state", 8'(state_dbg), 8'(S_FETCH));
    end

    // jal
    go_decode(OP_JAL, 3'b000, 1'b0, "jal");
    chk("jal_imd", 8'(imd_src), 8'd3);
    tick();
    chk("jal_state", 8'(state_dbg), 8'(S_JAL));
    chk("jal_pc_write", 8'(pc_write), 8'd1);
    chk("jal_src_a", 8'(alu_src_a), 8'd1);
    chk("jal_src_b", 8'(alu_src_b), 8'd2);
    chk("jal_reg_write", 8'(reg_write), 8'd0);
    tick();
    chk("jal_wb_state", 8'(state_dbg), 8'(S_ALUWB));
    chk("jal_wb_reg_write", 8'(reg_write), 8'd1);
    tick();
    chk("jal_end_state", 8'(state_dbg), 8'(S_FETCH));

    // illegal opcode and illegal funct3
    go_decode(7'b0000000, 3'b000, 1'b0, "ill_op");
    chk("ill_op_pulse", 8'(illegal_instr), 8'd1);
    tick();
    chk("ill_op_next", 8'(state_dbg), 8'(S_FETCH));
    chk("ill_op_clear", 8'(illegal_instr), 8'd0);
    go_decode(OP_R, 3'b001, 1'b0, "ill_f3");
    chk("ill_f3_pulse", 8'(illegal_instr), 8'd1);
    tick();
    chk("ill_f3_exec", 8'(state_dbg), 8'(S_EXEC_R));
    chk("ill_f3_ctrl", 8'(alu_ctrl), 8'd0);
    chk("ill_f3_clear", 8'(illegal_instr), 8'd0);
    tick();
    tick();

    // reset during a stalled store
    go_decode(OP_SW, 3'b010, 1'b0, "rst_sw");
    tick();
    tick();
    chk("rst_sw_stall", 8'(state_dbg), 8'(S_MEMWRITE));
    chk("rst_sw_strobe", 8'(mem_write), 8'd1);
    tick();
    chk("rst_sw_hold", 8'(mem_write), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sw_mem_write", 8'(mem_write), 8'd0);
    chk("rst_sw_state", 8'(state_dbg), 8'(S_FETCH));
    chk("rst_sw_reg_write", 8'(reg_write), 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_sw_after", 8'(state_dbg), 8'(S_FETCH));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
